// File: rtl/nios_switches_debounce.sv
// nios_switches_debounce: synchronise and per-bit debounce the slide switches feeding the Nios PIO in_port.
module nios_switches_debounce #(
  parameter int WIDTH = 10,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W = 19
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_changed,
  output logic             any_changed
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] stable_q, stable_d, changed_q, changed_d;
  logic             any_q, any_d;
  logic [WIDTH-1:0] s;
  assign s = sync_q[SYNC_STAGES-1];
  // A bit is accepted on the edge where its run of mismatches reaches DEBOUNCE_CYCLES;
  // any matching edge or an acceptance restarts that bit's count from zero.
  always_comb begin
    sync_d[0] = sw_raw;
    for (int k = 1; k < SYNC_STAGES; k++) sync_d[k] = sync_q[k-1];
    stable_d  = stable_q;
    changed_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      changed_d[i] = (s[i] != stable_q[i]) && (cnt_q[i] == CNT_LAST);
      stable_d[i]  = changed_d[i] ? s[i] : stable_q[i];
      cnt_d[i]     = ((s[i] != stable_q[i]) && !changed_d[i]) ? cnt_q[i] + CNT_W'(1) : '0;
    end
    any_d = |changed_d;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      stable_q  <= '0;
      changed_q <= '0;
      any_q     <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      changed_q <= changed_d;
      any_q     <= any_d;
    end
  end
  assign sw_stable   = stable_q;
  assign sw_changed  = changed_q;
  assign any_changed = any_q;
endmodule

// File: tb/tb_nios_switches_debounce.sv
// tb_nios_switches_debounce: directed and random stimulus against a sliding-window reference model.
module tb_nios_switches_debounce;
  localparam int W = 10;
  localparam int SYNC = 2;
  localparam int DC = 4;
  logic         clk, reset_n;
  logic [W-1:0] sw_raw, sw_stable, sw_changed;
  logic         any_changed;
  logic [W-1:0] raw_q [$];
  logic [W-1:0] s_hist [$];
  logic [W-1:0] stable_m, chg_m;
  int checks, errors;

  nios_switches_debounce #(.WIDTH(W), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DC), .CNT_W(2)) dut (
    .clk(clk), .reset_n(reset_n), .sw_raw(sw_raw),
    .sw_stable(sw_stable), .sw_changed(sw_changed), .any_changed(any_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: a bit flips when the last DC synchronised samples since reset all differ from it.
  task automatic tick(input logic [W-1:0] raw, input logic rn);
    logic [W-1:0] s_e, acc;
    @(negedge clk);
    sw_raw = raw;
    reset_n = rn;
    @(posedge clk);
    if (!rn) begin
      raw_q.delete();
      s_hist.delete();
      stable_m = '0;
      chg_m = '0;
    end else begin
      s_e = (raw_q.size() >= SYNC) ? raw_q[raw_q.size()-SYNC] : '0;
      raw_q.push_back(raw);
      s_hist.push_back(s_e);
      if (s_hist.size() > DC) void'(s_hist.pop_front());
      acc = '1;
      foreach (s_hist[j]) acc &= s_hist[j] ^ stable_m;
      if (s_hist.size() < DC) acc = '0;
      stable_m ^= acc;
      chg_m = acc;
    end
    #1;
    check("stable", sw_stable, stable_m);
    check("changed", sw_changed, chg_m);
    check("any", W'(any_changed), W'(|chg_m));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    sw_raw = '0;
    stable_m = '0;
    chg_m = '0;
    for (int k = 0; k < 3; k++) tick(10'h3FF, 1'b0);
    check("reset_stable", sw_stable, '0);
    for (int k = 1; k <= 7; k++) begin
      tick(10'h001, 1'b1);
      if (k == 5) check("rise_early", sw_stable, '0);
      if (k == 6) begin
        check("rise_stable", sw_stable, 10'h001);
        check("rise_pulse", sw_changed, 10'h001);
      end
      if (k == 7) check("rise_clear", W'(any_changed), '0);
    end
    tick(10'h009, 1'b1);
    tick(10'h001, 1'b1);
    tick(10'h009, 1'b1);
    tick(10'h001, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      tick(10'h009, 1'b1);
      if (k == 5) check("bounce_early", sw_stable, 10'h001);
      if (k == 6) check("bounce_pulse", sw_changed, 10'h008);
    end
    for (int k = 0; k < 8; k++) tick(10'h000, 1'b1);
    check("multi_base", sw_stable, '0);
    for (int k = 1; k <= 7; k++) begin
      tick(10'h2A5, 1'b1);
      if (k == 6) begin
        check("multi_stable", sw_stable, 10'h2A5);
        check("multi_pulse", sw_changed, 10'h2A5);
      end
    end
    tick(10'h200, 1'b0);
    for (int k = 0; k < 5; k++) tick(10'h200, 1'b1);
    tick(10'h200, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      tick(10'h200, 1'b1);
      if (k == 5) check("midrst_early", sw_stable, '0);
      if (k == 6) check("midrst_rise", sw_stable, 10'h200);
    end
    tick(10'h3FF, 1'b0);
    for (int k = 0; k < 7; k++) tick(10'h3FF, 1'b1);
    check("fall_base", sw_stable, 10'h3FF);
    for (int k = 1; k <= 7; k++) begin
      tick(10'h000, 1'b1);
      if (k == 6) begin
        check("fall_stable", sw_stable, '0);
        check("fall_pulse", sw_changed, 10'h3FF);
      end
    end
    begin
      logic [W-1:0] r;
      r = '0;
      for (int n = 0; n < 3000; n++) begin
        for (int b = 0; b < W; b++) if ($urandom_range(7) == 0) r[b] = ~r[b];
        tick(r, $urandom_range(199) != 0);
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
